minmax_scan_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 17 +
 rtl/slt_cmp.sv | 14 +
 rtl/minmax_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_minmax_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU-side controllers: the min/max scan FSM state
// encoding, the default operand width and a signed operand type.
package alu_ctrl_pkg;

    localparam int ALU_WIDTH = 6;

    typedef logic signed [ALU_WIDTH-1:0] alu_word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CMP_MIN = 3'd2,
        ST_CMP_MAX = 3'd3,
        ST_DONE    = 3'd4
    } mmx_state_t;

endpackage

// File: rtl/slt_cmp.sv
// Purely combinational signed less-than: lt = (a_i < b_i) in two's complement.
module slt_cmp
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             lt
);

    assign lt = $signed(a_i) < $signed(b_i);

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Min/max burst scanner. Accepts 1..MAX_LEN signed words over a valid/ready
// front end and tracks the running minimum and maximum with one shared
// signed less-than comparator (CMP_MIN checks x < min, CMP_MAX checks max < x).
// Strict less-than means ties keep the earliest index.
// Build option: define MINMAX_IDX_EN to compile in the min/max index
// registers; otherwise min_idx/max_idx are tied to 0.
//
// Handshake: a word is consumed on a rising edge where in_valid && in_ready;
// in_ready is high only in FETCH and, like busy/done/err, comes from
// registers only, so it never depends combinationally on any input.
// FSM state is visible as state_q for binding checkers.
module minmax_scan_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int MAX_LEN = 8,
    localparam int IW     = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IW:0]      len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [IW-1:0]    min_idx,
    output logic [IW-1:0]    max_idx
);

    localparam logic [IW:0]   LEN_MAX = (IW+1)'(MAX_LEN);
    localparam logic [IW:0]   LEN_ONE = (IW+1)'(1);
    localparam logic [IW-1:0] CNT_ONE = IW'(1);

    mmx_state_t        state_q, state_d;
    logic [IW:0]       len_q, len_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  min_q, min_d;
    logic [WIDTH-1:0]  max_q, max_d;
    logic              err_q, err_d;

    logic              len_legal;
    logic              last_elem;
    logic              first_load;
    logic [WIDTH-1:0]  cmp_a, cmp_b;
    logic              cmp_lt;

    assign len_legal  = (len != '0) && (len <= LEN_MAX);
    assign last_elem  = ({1'b0, cnt_q} == (len_q - LEN_ONE));
    assign first_load = (state_q == ST_FETCH) && in_valid && (cnt_q == '0);

    // Share the comparator: CMP_MAX asks max < x, every other state x < min.
    assign cmp_a = (state_q == ST_CMP_MAX) ? max_q : x_q;
    assign cmp_b = (state_q == ST_CMP_MAX) ? x_q   : min_q;

    slt_cmp #(.WIDTH(WIDTH)) u_slt_cmp (
        .a_i (cmp_a),
        .b_i (cmp_b),
        .lt  (cmp_lt)
    );

    // Next-state, counter and result-update logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        min_d   = min_q;
        max_d   = max_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_legal) begin
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        min_d = in_data;
                        max_d = in_data;
                        if (len_q == LEN_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = CNT_ONE;
                        end
                    end else begin
                        x_d     = in_data;
                        state_d = ST_CMP_MIN;
                    end
                end
            end
            ST_CMP_MIN: begin
                if (cmp_lt) begin
                    min_d = x_q;
                end
                state_d = ST_CMP_MAX;
            end
            ST_CMP_MAX: begin
                if (cmp_lt) begin
                    max_d = x_q;
                end
                if (last_elem) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            min_q   <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            min_q   <= min_d;
            max_q   <= max_d;
            err_q   <= err_d;
        end
    end

`ifdef MINMAX_IDX_EN
    logic [IW-1:0] min_idx_q, min_idx_d;
    logic [IW-1:0] max_idx_q, max_idx_d;

    // Index tracking follows the same decisions as the value updates.
    always_comb begin
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        if (first_load) begin
            min_idx_d = '0;
            max_idx_d = '0;
        end
        if ((state_q == ST_CMP_MIN) && cmp_lt) begin
            min_idx_d = cnt_q;
        end
        if ((state_q == ST_CMP_MAX) && cmp_lt) begin
            max_idx_d = cnt_q;
        end
    end

    // Index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else begin
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign min_idx = min_idx_q;
    assign max_idx = max_idx_q;
`else
    logic unused_first_load;
    assign unused_first_load = first_load;
    assign min_idx = '0;
    assign max_idx = '0;
`endif

    assign in_ready = (state_q == ST_FETCH);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign min_out  = min_q;
    assign max_out  = max_q;

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Directed bench for minmax_scan_ctrl: a table of bursts with hand-computed
// results and done cycles, plus sequences for illegal lengths and reset
// during a scan. Expected indices follow the MINMAX_IDX_EN build option.
module tb_minmax_scan_ctrl;

    localparam int WIDTH   = 6;
    localparam int MAX_LEN = 8;
    localparam int IW      = 3;

`ifdef MINMAX_IDX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    // Clock/reset and DUT signals.
    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [IW:0]             len;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_ready;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic signed [WIDTH-1:0] min_out;
    logic signed [WIDTH-1:0] max_out;
    logic [IW-1:0]           min_idx;
    logic [IW-1:0]           max_idx;

    always #5 clk = ~clk;

    minmax_scan_ctrl #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .min_out  (min_out),
        .max_out  (max_out),
        .min_idx  (min_idx),
        .max_idx  (max_idx)
    );

    typedef struct packed {
        logic [IW:0]                   len;
        logic [7:0][WIDTH-1:0]         data;
        logic                          stall;
        logic                          busy_start;
        int                            exp_min;
        int                            exp_min_idx;
        int                            exp_max;
        int                            exp_max_idx;
        int                            exp_done;
    } vec_t;

    vec_t vecs[5];
    int   n_total = 0;
    int   n_pass  = 0;

    // Scoreboard comparison.
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int eidx(input int i);
        return IDX_EN ? i : 0;
    endfunction

    function automatic vec_t mk(input int ln, input int d0, input int d1, input int d2,
                                input int d3, input int d4, input int d5, input int d6,
                                input int d7, input bit st, input bit bs, input int mn,
                                input int mni, input int mx, input int mxi, input int dc);
        vec_t r;
        r.len = ln[IW:0];
        r.data[0] = d0[WIDTH-1:0]; r.data[1] = d1[WIDTH-1:0];
        r.data[2] = d2[WIDTH-1:0]; r.data[3] = d3[WIDTH-1:0];
        r.data[4] = d4[WIDTH-1:0]; r.data[5] = d5[WIDTH-1:0];
        r.data[6] = d6[WIDTH-1:0]; r.data[7] = d7[WIDTH-1:0];
        r.stall = st; r.busy_start = bs;
        r.exp_min = mn; r.exp_min_idx = mni;
        r.exp_max = mx; r.exp_max_idx = mxi;
        r.exp_done = dc;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int mn, input int mni,
                                 input int mx, input int mxi);
        check({tag, "_min"},     int'(min_out), mn);
        check({tag, "_max"},     int'(max_out), mx);
        check({tag, "_min_idx"}, int'(min_idx), eidx(mni));
        check({tag, "_max_idx"}, int'(max_idx), eidx(mxi));
    endtask

    // Driver: one burst; cycle 0 is the cycle in which start is sampled.
    // With stall set, in_valid is low for 2 cycles after start and after
    // every accepted word.
    task automatic run_scan(input string tag, input vec_t v);
        int gap, w, done_cyc;
        bit err_seen;
        gap      = v.stall ? 2 : 0;
        w        = 0;
        done_cyc = -1;
        err_seen = 1'b0;
        start    = 1'b1;
        len      = v.len;
        in_valid = 1'b0;
        in_data  = v.data[0];
        for (int cyc = 1; cyc <= 60; cyc++) begin
            next_cycle();
            start = v.busy_start;
            len   = '0;
            if (err) err_seen = 1'b1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else begin
                in_valid = 1'b1;
            end
            in_data = v.data[w[2:0]];
            if (in_valid && in_ready) begin
                w++;
                gap = v.stall ? 2 : 0;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, v.exp_done);
        check({tag, "_words"}, w, int'(v.len));
        check({tag, "_no_err"}, int'(err_seen), 0);
        check_results(tag, v.exp_min, v.exp_min_idx, v.exp_max, v.exp_max_idx);
        next_cycle();
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_idle"}, int'(busy), 0);
        check_results({tag, "_hold"}, v.exp_min, v.exp_min_idx, v.exp_max, v.exp_max_idx);
    endtask

    task automatic illegal_start(input string tag, input int ln);
        int ln_v;
        ln_v  = ln;
        start = 1'b1;
        len   = ln_v[IW:0];
        next_cycle();
        start = 1'b0;
        len   = '0;
        check({tag, "_err"}, int'(err), 1);
        check({tag, "_busy"}, int'(busy), 0);
        next_cycle();
        check({tag, "_err_pulse"}, int'(err), 0);
        check({tag, "_busy2"}, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done_seen;
        vecs[0] = mk(4,  5, -3, 31, -32, 0, 0, 0, 0, 1'b0, 1'b0, -32, 3, 31, 2, 11);
        vecs[1] = mk(3,  7,  7,  7,   0, 0, 0, 0, 0, 1'b0, 1'b1,   7, 0,  7, 0,  8);
        vecs[2] = mk(1, -1,  0,  0,   0, 0, 0, 0, 0, 1'b0, 1'b0,  -1, 0, -1, 0,  2);
        vecs[3] = mk(3,  2, -8,  9,   0, 0, 0, 0, 0, 1'b1, 1'b0,  -8, 1,  9, 2, 12);
        vecs[4] = mk(8,  0, -1,  1, -32, 31, -32, 31, 0, 1'b0, 1'b1, -32, 3, 31, 4, 23);

        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check_results("rst", 0, 0, 0, 0);
        rst = 1'b0;
        next_cycle();

        foreach (vecs[i]) begin
            run_scan($sformatf("vec%0d", i), vecs[i]);
        end

        illegal_start("len0", 0);
        illegal_start("len9", 9);
        check_results("illegal_hold", -32, 3, 31, 4);

        // Reset while CMP_MIN processes element 2 of a len=4 burst.
        start    = 1'b1;
        len      = 4'd4;
        in_valid = 1'b1;
        in_data  = 6'd5;
        next_cycle();
        start   = 1'b0;
        len     = '0;
        in_data = 6'd5;
        next_cycle();
        in_data = 6'h3d;
        next_cycle();
        next_cycle();
        next_cycle();
        in_data = 6'd31;
        next_cycle();
        check("mid_busy", int'(busy), 1);
        check("mid_in_ready", int'(in_ready), 0);
        check("mid_min_running", int'(min_out), -3);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_done", int'(done), 0);
        check_results("mid_rst", 0, 0, 0, 0);
        in_valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (done || busy) done_seen = 1'b1;
        end
        check("mid_rst_no_done", int'(done_seen), 0);
        run_scan("rescan", vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
